// File: rtl/parking_meter_if.sv
// Parking meter control interface.
// Bundles the pulse/level requests coming from the input conditioning block
// and the time/status outputs going to the seven-segment display driver.
//   add_10/add_180/add_200/add_550 : one-cycle pulses, add the stated seconds
//   rst_to_10/rst_to_205           : levels, force the remaining time while high
//   time_left                      : remaining seconds (14 bits)
//   display_on                     : 1 = display lit, 0 = blanked
//   expired / low_time             : status flags
//   sec_tick                       : one-cycle pulse on each 1 s boundary
// master = request source (conditioning block / bench), slave = controller.
interface parking_meter_if;
  logic        add_10;
  logic        add_180;
  logic        add_200;
  logic        add_550;
  logic        rst_to_10;
  logic        rst_to_205;
  logic [13:0] time_left;
  logic        display_on;
  logic        expired;
  logic        low_time;
  logic        sec_tick;

  modport master (
    output add_10, add_180, add_200, add_550, rst_to_10, rst_to_205,
    input  time_left, display_on, expired, low_time, sec_tick
  );

  modport slave (
    input  add_10, add_180, add_200, add_550, rst_to_10, rst_to_205,
    output time_left, display_on, expired, low_time, sec_tick
  );
endinterface

// File: rtl/parking_meter_ctrl.sv
// Parking meter time-keeping controller.
// Keeps the remaining parking time in seconds, adds coins, applies presets,
// counts down once per second and drives the display blank/flash control.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   pm    : parking_meter_if.slave (add pulses, preset levels in;
//           time_left, display_on, expired, low_time, sec_tick out)
// All outputs are registered and reflect the inputs of the previous cycle.
module parking_meter_ctrl #(
  parameter int CLOCKS_PER_SEC = 100000000,
  parameter int MAX_TIME       = 9999,
  parameter int LOW_THRESHOLD  = 200
) (
  input  logic            clk,
  input  logic            rst_n,
  parking_meter_if.slave  pm
);

  localparam int CNT_W = $clog2(CLOCKS_PER_SEC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_SEC / 2);

  // 15-bit working width: 9999 + 940 cannot wrap.
  localparam logic [14:0] MAX_T = 15'(MAX_TIME);
  localparam logic [14:0] LOW_T = 15'(LOW_THRESHOLD);

  localparam logic [1:0] ST_EXPIRED = 2'd0;
  localparam logic [1:0] ST_LOW     = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  logic [13:0]      time_left_q,  time_left_d;
  logic [CNT_W-1:0] tick_cnt_q,   tick_cnt_d;
  logic             sec_parity_q, sec_parity_d;
  logic             sec_tick_q,   sec_tick_d;
  logic [1:0]       state_q,      state_d;
  logic             display_on_q, display_on_d;

  logic             tick_wrap;
  logic [14:0]      add_sum;
  logic [14:0]      dec;
  logic [14:0]      next_raw;

  function automatic logic [13:0] sat_time(input logic [14:0] v);
    logic [14:0] r;
    r = (v > MAX_T) ? MAX_T : v;
    return r[13:0];
  endfunction

  function automatic logic [1:0] decode_state(input logic [13:0] t);
    if (t == 14'd0)
      return ST_EXPIRED;
    else if ({1'b0, t} < LOW_T)
      return ST_LOW;
    else
      return ST_RUN;
  endfunction

  always_comb begin
    tick_wrap = (tick_cnt_q == CNT_LAST);

    add_sum = (pm.add_10  ? 15'd10  : 15'd0)
            + (pm.add_180 ? 15'd180 : 15'd0)
            + (pm.add_200 ? 15'd200 : 15'd0)
            + (pm.add_550 ? 15'd550 : 15'd0);

    // Decrement is suppressed at zero so the count never underflows.
    dec      = (tick_wrap && (time_left_q != 14'd0)) ? 15'd1 : 15'd0;
    next_raw = {1'b0, time_left_q} - dec + add_sum;

    tick_cnt_d   = tick_wrap ? '0 : tick_cnt_q + CNT_W'(1);
    sec_tick_d   = tick_wrap;
    sec_parity_d = sec_parity_q ^ tick_wrap;
    time_left_d  = sat_time(next_raw);

    // Presets override everything and hold the second timer at its start,
    // so the first decrement comes a full second after release.
    if (pm.rst_to_10) begin
      time_left_d  = 14'd10;
      tick_cnt_d   = '0;
      sec_parity_d = 1'b0;
      sec_tick_d   = 1'b0;
    end else if (pm.rst_to_205) begin
      time_left_d  = 14'd205;
      tick_cnt_d   = '0;
      sec_parity_d = 1'b0;
      sec_tick_d   = 1'b0;
    end

    // Display control is computed from next-state values so it changes on
    // the same edge as time_left rather than a cycle later.
    state_d = decode_state(time_left_d);
    case (state_d)
      ST_RUN:  display_on_d = 1'b1;
      ST_LOW:  display_on_d = ~sec_parity_d;
      default: display_on_d = (tick_cnt_d < CNT_HALF);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_left_q  <= '0;
      tick_cnt_q   <= '0;
      sec_parity_q <= 1'b0;
      sec_tick_q   <= 1'b0;
      state_q      <= ST_EXPIRED;
      display_on_q <= 1'b1;
    end else begin
      time_left_q  <= time_left_d;
      tick_cnt_q   <= tick_cnt_d;
      sec_parity_q <= sec_parity_d;
      sec_tick_q   <= sec_tick_d;
      state_q      <= state_d;
      display_on_q <= display_on_d;
    end
  end

  assign pm.time_left  = time_left_q;
  assign pm.display_on = display_on_q;
  assign pm.expired    = (state_q == ST_EXPIRED);
  assign pm.low_time   = (state_q == ST_LOW);
  assign pm.sec_tick   = sec_tick_q;

endmodule

// File: tb/tb_parking_meter_ctrl.sv
// Self-checking bench for parking_meter_ctrl with CLOCKS_PER_SEC = 10.
// Stimulus pushes expected output values tagged with the cycle in which they
// must appear; a separate monitor samples the outputs on every falling clock
// edge (and shortly after an asynchronous reset assertion) and compares them.
module tb_parking_meter_ctrl;
  localparam int CPS = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  parking_meter_if pm_if ();

  parking_meter_ctrl #(
    .CLOCKS_PER_SEC(CPS),
    .MAX_TIME      (9999),
    .LOW_THRESHOLD (200)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pm   (pm_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // sel: 0 time_left, 1 display_on, 2 expired, 3 low_time, 4 sec_tick
  typedef struct {
    int    cyc;
    int    sel;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   mon_got;

  function automatic int sample(input int sel);
    case (sel)
      0:       return int'(pm_if.time_left);
      1:       return int'(pm_if.display_on);
      2:       return int'(pm_if.expired);
      3:       return int'(pm_if.low_time);
      default: return int'(pm_if.sec_tick);
    endcase
  endfunction

  // Monitor
  always @(negedge clk or negedge rst_n) begin
    #1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.cyc < cyc) begin
        errors++;
        $display("FAIL %s missed: due cyc %0d, now cyc %0d", mon_e.name, mon_e.cyc, cyc);
      end else begin
        mon_got = sample(mon_e.sel);
        if (mon_got != mon_e.val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%0d expected=%0d", mon_e.name, cyc, mon_got, mon_e.val);
        end
      end
    end
  end

  task automatic push(input int c, input int sel, input int val, input string nm);
    exp_t e;
    e.cyc  = c;
    e.sel  = sel;
    e.val  = val;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic push_all(input int c, input int tl, input int disp, input int ex,
                          input int lo, input int tk, input string nm);
    push(c, 0, tl,   {nm, "_time_left"});
    push(c, 1, disp, {nm, "_display_on"});
    push(c, 2, ex,   {nm, "_expired"});
    push(c, 3, lo,   {nm, "_low_time"});
    push(c, 4, tk,   {nm, "_sec_tick"});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pm_if.add_10     = 1'b0;
    pm_if.add_180    = 1'b0;
    pm_if.add_200    = 1'b0;
    pm_if.add_550    = 1'b0;
    pm_if.rst_to_10  = 1'b0;
    pm_if.rst_to_205 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 500) begin
      step();
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never checked", sb.size());
      sb.delete();
    end
  endtask

  // Returns the cycle in which reset was released; outputs in that cycle
  // still show reset values and the tick counter starts from 0 there.
  task automatic do_reset(output int r);
    drain();
    step();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
    r = cyc;
    push_all(r, 0, 1, 1, 0, 0, "rst");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, t, u, v;
    rst_n = 1'b0;
    clear_inputs();

    // Idle after reset: expired, 5/5 flash, sec_tick every 10 cycles.
    do_reset(r);
    for (int k = 1; k < 30; k++)
      push_all(r + k, 0, ((k % 10) < 5) ? 1 : 0, 1, 0, ((k % 10) == 0) ? 1 : 0, "idle");
    for (int k = 0; k < 30; k++) step();

    // Repeated add_550 up to saturation; one decrement lands on pulse 10.
    do_reset(r);
    for (int i = 0; i < 19; i++) begin
      pm_if.add_550 = 1'b1;
      v = 550 * (i + 1) - ((i >= 9) ? 1 : 0);
      if (v > 9999) v = 9999;
      push(cyc + 1, 0, v, "sat_climb");
      step();
    end
    pm_if.add_550 = 1'b0;
    pm_if.add_10  = 1'b1;
    push_all(cyc + 1, 9999, 1, 0, 0, 1, "sat_add10_dec");
    step();
    pm_if.add_10 = 1'b0;
    push(cyc + 1, 0, 9999, "sat_hold");
    step();
    step();

    // rst_to_205 held for 25 cycles, then released.
    do_reset(r);
    pm_if.rst_to_205 = 1'b1;
    for (int j = 1; j <= 25; j++)
      push_all(r + j, 205, 1, 0, 0, 0, "p205_held");
    for (int j = 0; j < 25; j++) step();
    pm_if.rst_to_205 = 1'b0;
    t = cyc;
    for (int j = 1; j <= 10; j++) begin
      push(t + j, 0, (j < 10) ? 205 : 204, "p205_run");
      push(t + j, 4, (j == 10) ? 1 : 0, "p205_tick");
      push(t + j, 3, 0, "p205_low");
    end
    for (int j = 0; j < 11; j++) step();

    // rst_to_10 then run down to zero and into the expired flash.
    do_reset(r);
    pm_if.rst_to_10 = 1'b1;
    t = cyc + 1;
    for (int j = 0; j < 110; j++) begin
      v = 10 - (j / 10);
      if (v < 0) v = 0;
      push_all(t + j, v,
               (v > 0) ? (((j / 10) % 2 == 0) ? 1 : 0) : (((j % 10) < 5) ? 1 : 0),
               (v == 0) ? 1 : 0, (v > 0) ? 1 : 0,
               ((j % 10) == 0 && j > 0) ? 1 : 0, "run10");
    end
    step();
    pm_if.rst_to_10 = 1'b0;
    for (int j = 0; j < 110; j++) step();

    // All four adds at once from zero; add_10 coincident with a decrement.
    do_reset(r);
    pm_if.add_10  = 1'b1;
    pm_if.add_180 = 1'b1;
    pm_if.add_200 = 1'b1;
    pm_if.add_550 = 1'b1;
    push_all(r + 1, 940, 1, 0, 0, 0, "add_all");
    step();
    clear_inputs();
    pm_if.rst_to_10 = 1'b1;
    step();
    pm_if.rst_to_10 = 1'b0;
    t = cyc;
    push(t, 0, 10, "tick_add_pre10");
    push(t + 59, 0, 5, "tick_add_pre5");
    push(t + 60, 0, 14, "tick_add_sum");
    push(t + 60, 4, 1, "tick_add_tick");
    push(t + 61, 0, 14, "tick_add_hold");
    for (int j = 0; j < 59; j++) step();
    pm_if.add_10 = 1'b1;
    step();
    pm_if.add_10 = 1'b0;
    step();
    step();

    // Build up 300 s, then assert reset between clock edges.
    do_reset(r);
    pm_if.rst_to_10 = 1'b1;
    step();
    pm_if.rst_to_10 = 1'b0;
    u = cyc;
    pm_if.add_200 = 1'b1;
    pm_if.add_10  = 1'b1;
    push(u + 1, 0, 220, "build_220");
    push_all(u + 9, 300, 1, 0, 0, 0, "build_300");
    step();
    pm_if.add_200 = 1'b0;
    for (int j = 0; j < 8; j++) step();
    pm_if.add_10 = 1'b0;
    @(negedge clk);
    #2;
    push_all(cyc, 0, 1, 1, 0, 0, "async_rst");
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    r = cyc;
    push_all(r, 0, 1, 1, 0, 0, "post_rst");
    push(r + 1, 4, 0, "post_rst_tick1");
    push(r + 9, 4, 0, "post_rst_tick9");
    push(r + 10, 4, 1, "post_rst_tick10");
    for (int j = 0; j < 10; j++) step();
    pm_if.rst_to_10  = 1'b1;
    pm_if.rst_to_205 = 1'b1;
    push_all(cyc + 1, 10, 1, 0, 1, 0, "both_presets");
    step();
    clear_inputs();
    step();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
